lstm_train_ctrl: RTL and testbench

LSTM_TRAIN_CTRL -- requirements
Module: lstm_train_ctrl

---
 rtl/lstm_train_ctrl.sv | 171 +++++++++++++++++
 tb/tb_lstm_train_ctrl.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/lstm_train_ctrl.sv
// Sequencing controller for one LSTM training run: label preload, per-timestep
// input fill/latch/settle/capture, and a weight update at the end of each epoch.
module lstm_train_ctrl #(
    parameter int unsigned WIDTH          = 32,
    parameter int unsigned NUM            = 45,
    parameter int unsigned NUM_ITERATIONS = 8,
    parameter int unsigned NUM_LABELS     = 8,
    parameter int unsigned SETTLE         = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_start,
    input  logic             i_abort,
    input  logic [15:0]      i_epochs,
    input  logic [WIDTH-1:0] i_t_base,
    output logic             o_busy,
    output logic             o_done,
    output logic             o_sel,
    output logic             o_load_in,
    output logic             o_load_bp,
    output logic             o_load_t,
    output logic             o_load_h,
    output logic             o_wr,
    output logic [WIDTH-1:0] o_addr_t,
    output logic [7:0]       o_step,
    output logic [15:0]      o_epoch
);

    typedef enum logic [2:0] {
        IDLE, LOAD_T, FILL, LATCH, SETTLE_W, CAPTURE, UPDATE, DONE
    } state_t;

    state_t           state_q, state_d;
    logic [15:0]      cnt_q, cnt_d;
    logic [7:0]       step_q, step_d;
    logic [15:0]      epoch_q, epoch_d;
    logic [15:0]      epochs_q, epochs_d;
    logic [WIDTH-1:0] addr_q, addr_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             sel_q, sel_d;
    logic             load_in_q, load_in_d;
    logic             load_h_q, load_h_d;
    logic             load_t_q, load_t_d;
    logic             wr_q, wr_d;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        step_d   = step_q;
        epoch_d  = epoch_q;
        epochs_d = epochs_q;
        addr_d   = addr_q;

        unique case (state_q)
            IDLE: begin
                if (i_start) begin
                    epochs_d = (i_epochs == '0) ? 16'd1 : i_epochs;
                    addr_d   = i_t_base;
                    cnt_d    = '0;
                    step_d   = '0;
                    epoch_d  = '0;
                    state_d  = LOAD_T;
                end
            end
            LOAD_T: begin
                if (cnt_q == 16'(NUM_LABELS - 1)) begin
                    cnt_d   = '0;
                    state_d = FILL;
                end else begin
                    cnt_d  = cnt_q + 16'd1;
                    addr_d = addr_q + WIDTH'(1);
                end
            end
            FILL: begin
                if (cnt_q == 16'(NUM - 1)) begin
                    cnt_d   = '0;
                    state_d = LATCH;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            LATCH: state_d = SETTLE_W;
            SETTLE_W: begin
                if (cnt_q == 16'(SETTLE - 1)) begin
                    cnt_d   = '0;
                    state_d = CAPTURE;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            CAPTURE: begin
                step_d  = step_q + 8'd1;
                state_d = (step_q + 8'd1 == 8'(NUM_ITERATIONS)) ? UPDATE : FILL;
            end
            UPDATE: begin
                epoch_d = epoch_q + 16'd1;
                step_d  = '0;
                state_d = (epoch_q + 16'd1 == epochs_q) ? DONE : FILL;
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // Abort overrides whatever the case above scheduled, so no pulse survives it.
        if (i_abort && state_q != IDLE) begin
            state_d = IDLE;
            cnt_d   = '0;
            step_d  = step_q;
            epoch_d = epoch_q;
            addr_d  = addr_q;
        end
    end

    // Outputs are decoded from the next state so each registered pulse lines up with its state.
    always_comb begin
        busy_d    = (state_d != IDLE);
        done_d    = (state_d == DONE);
        load_t_d  = (state_d == LOAD_T);
        load_in_d = (state_d == LATCH);
        load_h_d  = (state_d == CAPTURE);
        wr_d      = (state_d == UPDATE);
        sel_d     = (state_d == UPDATE) ||
                    ((state_d inside {FILL, LATCH, SETTLE_W, CAPTURE}) && (step_d != '0));
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            step_q    <= '0;
            epoch_q   <= '0;
            epochs_q  <= '0;
            addr_q    <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            sel_q     <= 1'b0;
            load_in_q <= 1'b0;
            load_h_q  <= 1'b0;
            load_t_q  <= 1'b0;
            wr_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            step_q    <= step_d;
            epoch_q   <= epoch_d;
            epochs_q  <= epochs_d;
            addr_q    <= addr_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            sel_q     <= sel_d;
            load_in_q <= load_in_d;
            load_h_q  <= load_h_d;
            load_t_q  <= load_t_d;
            wr_q      <= wr_d;
        end
    end

    assign o_busy    = busy_q;
    assign o_done    = done_q;
    assign o_sel     = sel_q;
    assign o_load_in = load_in_q;
    assign o_load_bp = load_h_q;
    assign o_load_t  = load_t_q;
    assign o_load_h  = load_h_q;
    assign o_wr      = wr_q;
    assign o_addr_t  = addr_q;
    assign o_step    = step_q;
    assign o_epoch   = epoch_q;

endmodule

// File: tb/tb_lstm_train_ctrl.sv
// Scoreboard bench for lstm_train_ctrl: expected load/capture/update/done events are
// queued at start time and a negedge monitor pops and checks them as they appear.
module tb_lstm_train_ctrl;

    localparam int STEP_CYC  = 49;   // 45 fill + latch + 2 settle + capture
    localparam int EPOCH_CYC = 393;  // 8 steps * 49 + update
    localparam int LBL       = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_start, i_abort;
    logic [15:0] i_epochs;
    logic [31:0] i_t_base;
    logic        o_busy, o_done, o_sel, o_load_in, o_load_bp, o_load_t, o_load_h, o_wr;
    logic [31:0] o_addr_t;
    logic [7:0]  o_step;
    logic [15:0] o_epoch;

    lstm_train_ctrl #(
        .WIDTH(32), .NUM(45), .NUM_ITERATIONS(8), .NUM_LABELS(8), .SETTLE(2)
    ) dut (
        .clk(clk), .rst(rst), .i_start(i_start), .i_abort(i_abort),
        .i_epochs(i_epochs), .i_t_base(i_t_base),
        .o_busy(o_busy), .o_done(o_done), .o_sel(o_sel), .o_load_in(o_load_in),
        .o_load_bp(o_load_bp), .o_load_t(o_load_t), .o_load_h(o_load_h), .o_wr(o_wr),
        .o_addr_t(o_addr_t), .o_step(o_step), .o_epoch(o_epoch)
    );

    always #5 clk = ~clk;

    longint cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef enum int {EV_LOADT, EV_CAP, EV_WR, EV_DONE} ev_kind_t;
    typedef struct {
        ev_kind_t    kind;
        longint      at;
        logic [31:0] addr;
        logic        sel;
        logic [7:0]  step;
        logic [15:0] epoch;
    } exp_t;

    exp_t   q[$];
    int     n_cmp = 0;
    int     n_bad = 0;
    int     ctrl_viol = 0;
    longint run_base = 0;

    function automatic void push(ev_kind_t k, longint at, logic [31:0] a, logic s,
                                 logic [7:0] st, logic [15:0] ep);
        exp_t e;
        e.kind = k; e.at = at; e.addr = a; e.sel = s; e.step = st; e.epoch = ep;
        q.push_back(e);
    endfunction

    // Events at cycle offsets from the start edge; anything after cutoff is not expected.
    function automatic void push_run(longint base, logic [31:0] tb, int epochs, longint cutoff);
        longint c;
        for (int k = 0; k < LBL; k++)
            if (k <= cutoff) push(EV_LOADT, base + k, tb + 32'(k), 1'b0, 8'd0, 16'd0);
        for (int e = 0; e < epochs; e++) begin
            for (int s = 0; s < 8; s++) begin
                c = LBL + e * EPOCH_CYC + s * STEP_CYC + 48;
                if (c <= cutoff) push(EV_CAP, base + c, 32'd0, (s != 0), 8'(s), 16'(e));
            end
            c = LBL + e * EPOCH_CYC + 392;
            if (c <= cutoff) push(EV_WR, base + c, 32'd0, 1'b1, 8'd0, 16'(e));
        end
        c = LBL + epochs * EPOCH_CYC;
        if (c <= cutoff) push(EV_DONE, base + c, 32'd0, 1'b0, 8'd0, 16'(epochs));
    endfunction

    function automatic void chk(string name, longint act, longint exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    task automatic check_ev(input ev_kind_t k);
        exp_t e;
        logic ok;
        n_cmp++;
        if (q.size() == 0) begin
            n_bad++;
            $display("FAIL unexpected_%s at cycle %0d", k.name(), cyc);
            return;
        end
        e  = q.pop_front();
        ok = (e.kind == k) && (e.at == cyc);
        case (k)
            EV_LOADT: ok = ok && (o_addr_t == e.addr);
            EV_CAP:   ok = ok && (o_sel == e.sel) && (o_step == e.step);
            EV_WR:    ok = ok && (o_sel == e.sel) && (o_epoch == e.epoch);
            EV_DONE:  ok = ok && (o_epoch == e.epoch);
            default:  ok = 1'b0;
        endcase
        if (!ok) begin
            n_bad++;
            $display("FAIL event_%s: got kind=%s cyc=%0d addr=%0d sel=%0b step=%0d epoch=%0d expected kind=%s cyc=%0d addr=%0d sel=%0b step=%0d epoch=%0d",
                     k.name(), k.name(), cyc, o_addr_t, o_sel, o_step, o_epoch,
                     e.kind.name(), e.at, e.addr, e.sel, e.step, e.epoch);
        end
    endtask

    always @(negedge clk) begin
        if (rst) begin
            if ((int'(o_load_t) + int'(o_load_in) + int'(o_load_h) + int'(o_wr)) > 1 ||
                (o_load_bp != o_load_h))
                ctrl_viol++;
            if (o_load_t) check_ev(EV_LOADT);
            if (o_load_h) check_ev(EV_CAP);
            if (o_wr)     check_ev(EV_WR);
            if (o_done)   check_ev(EV_DONE);
        end
    end

    task automatic go(input logic [15:0] ep, input logic [31:0] base, input int eff_ep,
                      input longint cutoff);
        @(negedge clk);
        i_epochs = ep;
        i_t_base = base;
        i_start  = 1'b1;
        run_base = cyc + 1;
        push_run(run_base, base, eff_ep, cutoff);
        @(negedge clk);
        i_start = 1'b0;
    endtask

    task automatic wait_c(input longint c);
        while (cyc - run_base < c) @(negedge clk);
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while (q.size() != 0 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        chk({name, "_pending_events"}, q.size(), 0);
        q.delete();
        n = 0;
        while (o_busy && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk({name, "_idle"}, o_busy, 0);
    endtask

    task automatic idle_gap(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    function automatic longint all_outs();
        return longint'({o_busy, o_done, o_sel, o_load_in, o_load_bp, o_load_t, o_load_h,
                         o_wr, o_addr_t, o_step, o_epoch});
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1);
    end

    initial begin
        rst = 1'b0; i_start = 1'b0; i_abort = 1'b0; i_epochs = '0; i_t_base = '0;
        idle_gap(3);
        chk("reset_outputs", all_outs(), 0);
        rst = 1'b1;
        idle_gap(2);
        chk("idle_after_reset", o_busy, 0);

        // Single epoch, labels at 16..23, plus direct sel/latch probes.
        go(16'd1, 32'd16, 1, 1_000_000);
        wait_c(8);  chk("sel_step0_fill", o_sel, 0);
        wait_c(53); chk("load_in_latch", o_load_in, 1);
        wait_c(54); chk("load_in_settle", o_load_in, 0);
        wait_c(57); chk("sel_step1_fill", o_sel, 1);
        drain("one_epoch");
        idle_gap(3);

        go(16'd3, 32'd100, 3, 1_000_000);
        drain("three_epochs");
        idle_gap(3);

        go(16'd0, 32'd7, 1, 1_000_000);
        drain("zero_epochs");
        idle_gap(3);

        // Abort in the FILL phase of step 5.
        go(16'd1, 32'd0, 1, LBL + 5 * STEP_CYC + 10);
        wait_c(LBL + 5 * STEP_CYC + 10);
        i_abort = 1'b1;
        @(negedge clk);
        i_abort = 1'b0;
        chk("abort5_busy", o_busy, 0);
        chk("abort5_loads", {o_load_t, o_load_in, o_load_h, o_wr, o_done}, 0);
        idle_gap(450);
        drain("abort5");
        go(16'd1, 32'd16, 1, 1_000_000);
        drain("after_abort");
        idle_gap(3);

        // Abort on the final capture cycle, where the update pulse is already scheduled.
        go(16'd2, 32'd0, 2, 399);
        wait_c(399);
        i_abort = 1'b1;
        @(negedge clk);
        i_abort = 1'b0;
        chk("abort_vs_wr", o_wr, 0);
        chk("abort_vs_wr_busy", o_busy, 0);
        idle_gap(50);
        drain("abort_last");
        idle_gap(3);

        // Reset pulse mid-FILL, then a run with a stray start request.
        go(16'd1, 32'h40, 1, 20);
        wait_c(20);
        rst = 1'b0;
        #1;
        chk("rst_async_outputs", all_outs(), 0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("rst_release_idle", o_busy, 0);
        drain("rst_mid");
        go(16'd1, 32'h80, 1, 1_000_000);
        wait_c(100);
        i_start = 1'b1; i_epochs = 16'd5; i_t_base = 32'h999;
        @(negedge clk);
        i_start = 1'b0;
        chk("start_ignored_busy", o_busy, 1);
        drain("restart_ignored");

        chk("ctrl_onehot_violations", ctrl_viol, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
